// File: rtl/rr_arbiter_if.sv
// Handshake bundle between N requesters, the round-robin arbiter and the downstream consumer.
// The arbiter connects through the slave modport; the requester/consumer side uses master.
interface rr_arbiter_if #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1,
  parameter int CNT_W = 16
);
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_last;
  logic [N-1:0]     req_ready;
  logic [N-1:0]     grant;
  logic             out_valid;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic             out_ready;
  logic             locked;
  logic [CNT_W-1:0] pkt_cnt;

  modport master (
    output req_valid, req_last, out_ready,
    input  req_ready, grant, out_valid, out_idx, out_last, locked, pkt_cnt
  );

  modport slave (
    input  req_valid, req_last, out_ready,
    output req_ready, grant, out_valid, out_idx, out_last, locked, pkt_cnt
  );
endinterface

// File: rtl/rr_arbiter.sv
// Packet-aware round-robin arbiter: N valid/ready streams merged onto one output, no interleaving.
// Optional completed-packet counter enabled by defining RR_ARB_PKT_CNT_EN.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  rr_arbiter_if.slave bus
);
  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] sel, cur_idx;
  logic [IDX_W:0]   cand;
  logic             found, xfer, out_valid, out_last;
  logic [N-1:0]     grant;

  // Explicit compare so non-power-of-2 N wraps N-1 -> 0.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] x);
    return (x == IDX_W'(N - 1)) ? '0 : x + 1'b1;
  endfunction

  always_comb begin
    sel   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr_q} + (IDX_W + 1)'(k);
      if (cand >= (IDX_W + 1)'(N)) cand = cand - (IDX_W + 1)'(N);
      if (!found && bus.req_valid[cand[IDX_W-1:0]]) begin
        sel   = cand[IDX_W-1:0];
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    grant     = '0;
    cur_idx   = '0;
    out_valid = 1'b0;
    if (state_q == LOCKED) begin
      // Owner keeps the grant through bubbles until its last beat is accepted.
      cur_idx        = owner_q;
      grant[owner_q] = 1'b1;
      out_valid      = bus.req_valid[owner_q];
    end else if (found) begin
      cur_idx    = sel;
      grant[sel] = 1'b1;
      out_valid  = 1'b1;
    end
    out_last = out_valid & bus.req_last[cur_idx];
    xfer     = out_valid & bus.out_ready;
    if (xfer) begin
      if (out_last) begin
        state_d = IDLE;
        ptr_d   = wrap_inc(cur_idx);
      end else begin
        state_d = LOCKED;
        owner_d = cur_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  assign bus.grant     = grant;
  assign bus.out_valid = out_valid;
  assign bus.out_idx   = cur_idx;
  assign bus.out_last  = out_last;
  assign bus.req_ready = grant & {N{bus.out_ready}};
  assign bus.locked    = (state_q == LOCKED);

`ifdef RR_ARB_PKT_CNT_EN
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;

  assign pkt_cnt_d = (xfer & out_last) ? pkt_cnt_q + 1'b1 : pkt_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pkt_cnt_q <= '0;
    else     pkt_cnt_q <= pkt_cnt_d;
  end

  assign bus.pkt_cnt = pkt_cnt_q;
`else
  assign bus.pkt_cnt = '0;
`endif
endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter: N=4 (CNT_W=2) and N=3 instances on a shared clock and reset.
// Expected values are hand-computed; pkt_cnt expectations follow RR_ARB_PKT_CNT_EN.
module tb_rr_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   n_pkts   = 0;

  always #5 clk = ~clk;

  rr_arbiter_if #(.N(4), .CNT_W(2)) b4 ();
  rr_arbiter_if #(.N(3))            b3 ();

  rr_arbiter #(.N(4), .CNT_W(2)) dut4 (.clk(clk), .rst(rst), .bus(b4.slave));
  rr_arbiter #(.N(3))            dut3 (.clk(clk), .rst(rst), .bus(b3.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pk(input int n);
`ifdef RR_ARB_PKT_CNT_EN
    return 32'(n % 4);
`else
    return 32'd0;
`endif
  endfunction

  task automatic set4(input logic [3:0] v, input logic [3:0] l, input logic r);
    @(negedge clk);
    b4.req_valid = v;
    b4.req_last  = l;
    b4.out_ready = r;
    #1;
  endtask

  task automatic set3(input logic [2:0] v, input logic [2:0] l, input logic r);
    @(negedge clk);
    b3.req_valid = v;
    b3.req_last  = l;
    b3.out_ready = r;
    #1;
  endtask

  initial begin
    logic [3:0] oh;
    rst          = 1'b1;
    b4.req_valid = '0; b4.req_last = '0; b4.out_ready = 1'b0;
    b3.req_valid = '0; b3.req_last = '0; b3.out_ready = 1'b0;
    @(posedge clk); #2;
    check("rst_grant",     b4.grant, 0);
    check("rst_out_valid", b4.out_valid, 0);
    check("rst_out_idx",   b4.out_idx, 0);
    check("rst_out_last",  b4.out_last, 0);
    check("rst_req_ready", b4.req_ready, 0);
    check("rst_locked",    b4.locked, 0);
    check("rst_pkt_cnt",   b4.pkt_cnt, 0);
    check("rst_grant3",    b3.grant, 0);
    @(negedge clk) rst = 1'b0;

    // Fair rotation of single-beat packets
    for (int k = 0; k < 8; k++) begin
      set4(4'b1111, 4'b1111, 1'b1);
      oh = 4'b0001 << (k % 4);
      check($sformatf("rot%0d_idx", k),   b4.out_idx, 32'(k % 4));
      check($sformatf("rot%0d_grant", k), b4.grant, oh);
      check($sformatf("rot%0d_ready", k), b4.req_ready, oh);
      @(posedge clk); #1;
      n_pkts++;
      check($sformatf("rot%0d_pkt_cnt", k), b4.pkt_cnt, pk(n_pkts));
    end

    // Single beat from req 0 moves ptr to 1
    set4(4'b0001, 4'b0001, 1'b1);
    check("r0_grant", b4.grant, 4'b0001);
    @(posedge clk); #1;
    n_pkts++;

    // Req 1 three-beat packet with req 0 and 2 competing
    set4(4'b0111, 4'b0000, 1'b1);
    check("p1_b1_grant", b4.grant, 4'b0010);
    check("p1_b1_last",  b4.out_last, 0);
    @(posedge clk); #1;
    check("p1_b1_locked", b4.locked, 1);
    set4(4'b0111, 4'b0000, 1'b0);
    check("p1_stall_grant", b4.grant, 4'b0010);
    check("p1_stall_ready", b4.req_ready, 4'b0000);
    check("p1_stall_valid", b4.out_valid, 1);
    @(posedge clk); #1;
    check("p1_stall_locked", b4.locked, 1);
    set4(4'b0111, 4'b0000, 1'b1);
    check("p1_b2_grant", b4.grant, 4'b0010);
    check("p1_b2_ready", b4.req_ready, 4'b0010);
    @(posedge clk); #1;
    set4(4'b0101, 4'b0101, 1'b1);
    check("p1_bubble_grant", b4.grant, 4'b0010);
    check("p1_bubble_valid", b4.out_valid, 0);
    @(posedge clk); #1;
    check("p1_bubble_locked", b4.locked, 1);
    set4(4'b0111, 4'b0010, 1'b1);
    check("p1_b3_grant", b4.grant, 4'b0010);
    check("p1_b3_last",  b4.out_last, 1);
    @(posedge clk); #1;
    n_pkts++;
    check("p1_done_locked",  b4.locked, 0);
    check("p1_done_pkt_cnt", b4.pkt_cnt, pk(n_pkts));
    set4(4'b0101, 4'b0101, 1'b0);
    check("after_p1_grant", b4.grant, 4'b0100);
    check("after_p1_idx",   b4.out_idx, 2);

    // Reset while req 2 holds the lock
    set4(4'b0101, 4'b0000, 1'b1);
    @(posedge clk); #1;
    check("p2_locked", b4.locked, 1);
    @(negedge clk);
    rst = 1'b1;
    b4.out_ready = 1'b0;
    #1;
    n_pkts = 0;
    check("midrst_locked",  b4.locked, 0);
    check("midrst_grant",   b4.grant, 4'b0001);
    check("midrst_pkt_cnt", b4.pkt_cnt, 0);
    @(negedge clk) rst = 1'b0;
    set4(4'b0101, 4'b0101, 1'b1);
    check("postrst_idx", b4.out_idx, 0);
    @(posedge clk); #1;
    n_pkts++;
    check("postrst_pkt_cnt", b4.pkt_cnt, pk(n_pkts));
    set4(4'b0000, 4'b0000, 1'b0);

    // N=3 wrap from index 2 back to 0
    set3(3'b100, 3'b100, 1'b1);
    check("n3_idx2",   b3.out_idx, 2);
    check("n3_grant2", b3.grant, 3'b100);
    @(posedge clk); #1;
    set3(3'b011, 3'b011, 1'b0);
    check("n3_wrap_idx",   b3.out_idx, 0);
    check("n3_wrap_grant", b3.grant, 3'b001);
    set3(3'b011, 3'b011, 1'b1);
    @(posedge clk); #1;
    set3(3'b011, 3'b011, 1'b0);
    check("n3_next_idx", b3.out_idx, 1);
    check("n3_locked",   b3.locked, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
